// File: rtl/module1_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : module1_frame_loader
//  Purpose  : Deserialises a DW-bit chunk stream into one {f3,f2,f1} frame
//             for module1, with valid/ready output and frame-length checking.
//  Revision : 1.0
// ============================================================================
module module1_frame_loader #(
   parameter int P1 = 4,
   parameter int P2 = 5,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [P1-1:0] f1,
   output logic [P2-1:0] f2,
   output logic [3:0]    f3,
   output logic          err_short,
   output logic          err_long,
   output logic [15:0]   frame_cnt
);

   localparam int TOTAL  = P1 + P2 + 4;
   localparam int NCHUNK = (TOTAL + DW - 1) / DW;
   localparam int SHW    = NCHUNK * DW;
   localparam int IDXW   = $clog2(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_DROP = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q;
   logic [IDXW-1:0] idx_q;
   logic [SHW-1:0]  shift_q;
   logic [P1-1:0]   f1_q;
   logic [P2-1:0]   f2_q;
   logic [3:0]      f3_q;
   logic            m_valid_q;
   logic            err_short_q;
   logic            err_long_q;
   logic [15:0]     frame_cnt_q;

   logic            w_take;
   logic            w_fill_take;
   logic [IDXW-1:0] w_idx;
   logic [SHW-1:0]  w_frame;

   assign s_ready = (state_q == S_HOLD) ? m_ready : 1'b1;
   assign w_take  = s_valid && s_ready;
   assign w_fill_take = w_take && (state_q != S_DROP);

   // A chunk taken while delivering from HOLD always starts a new frame.
   always_comb begin
      w_idx   = (state_q == S_HOLD) ? '0 : idx_q;
      w_frame = shift_q;
      w_frame[int'(w_idx)*DW +: DW] = s_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         idx_q       <= '0;
         shift_q     <= '0;
         f1_q        <= '0;
         f2_q        <= '0;
         f3_q        <= '0;
         m_valid_q   <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;

         if (state_q == S_HOLD && m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= S_FILL;
            idx_q     <= '0;
         end

         if (state_q == S_DROP && w_take && s_last) begin
            state_q <= S_FILL;
            idx_q   <= '0;
         end

         if (w_fill_take) begin
            if (w_idx == LAST_IDX) begin
               idx_q <= '0;
               if (s_last) begin
                  f1_q        <= w_frame[P1-1:0];
                  f2_q        <= w_frame[P1 +: P2];
                  f3_q        <= w_frame[P1+P2 +: 4];
                  m_valid_q   <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= S_HOLD;
               end else begin
                  err_long_q <= 1'b1;
                  state_q    <= S_DROP;
               end
            end else if (s_last) begin
               err_short_q <= 1'b1;
               idx_q       <= '0;
               state_q     <= S_FILL;
            end else begin
               shift_q <= w_frame;
               idx_q   <= w_idx + 1'b1;
               state_q <= S_FILL;
            end
         end
      end
   end

   assign m_valid   = m_valid_q;
   assign f1        = f1_q;
   assign f2        = f2_q;
   assign f3        = f3_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_module1_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_module1_frame_loader
//  Purpose  : Directed stimulus for module1_frame_loader against a queue-based
//             frame model, plus hand-computed literal expectations.
//  Revision : 1.0
// ============================================================================
module tb_module1_frame_loader;

   localparam int P1     = 4;
   localparam int P2     = 5;
   localparam int DW     = 4;
   localparam int TOTAL  = P1 + P2 + 4;
   localparam int NCHUNK = (TOTAL + DW - 1) / DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [P1-1:0] f1;
   logic [P2-1:0] f2;
   logic [3:0]    f3;
   logic          err_short;
   logic          err_long;
   logic [15:0]   frame_cnt;

   module1_frame_loader #(.P1(P1), .P2(P2), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready),
      .f1(f1), .f2(f2), .f3(f3),
      .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Model state: chunks of the frame in progress, plus expected outputs.
   logic [DW-1:0] mq[$];
   bit            m_hold, m_drop, acc;
   logic          m_mv, m_es, m_el;
   logic [P1-1:0] m_f1;
   logic [P2-1:0] m_f2;
   logic [3:0]    m_f3;
   int unsigned   m_loads;
   int unsigned   cnt_base;
   longint        fr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_hold = 0; m_drop = 0;
         m_mv = 0; m_es = 0; m_el = 0;
         m_f1 = '0; m_f2 = '0; m_f3 = '0;
         m_loads = 0;
      end else begin
         acc  = s_valid && (m_hold ? m_ready : 1'b1);
         m_es = 0;
         m_el = 0;
         if (m_hold && m_ready) begin
            m_hold = 0;
            m_mv   = 0;
         end
         if (acc) begin
            if (m_drop) begin
               if (s_last) m_drop = 0;
            end else begin
               mq.push_back(s_data);
               if (mq.size() == NCHUNK) begin
                  if (s_last) begin
                     fr = 0;
                     foreach (mq[k]) fr = fr + (longint'(mq[k]) << (k * DW));
                     fr = fr % (longint'(1) << TOTAL);
                     m_f1 = P1'(fr);
                     m_f2 = P2'(fr >> P1);
                     m_f3 = 4'(fr >> (P1 + P2));
                     m_mv = 1; m_hold = 1;
                     m_loads = m_loads + 1;
                  end else begin
                     m_el = 1; m_drop = 1;
                  end
                  mq.delete();
               end else if (s_last) begin
                  m_es = 1;
                  mq.delete();
               end
            end
         end
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      check("m_valid",   32'(m_valid),   32'(m_mv));
      check("s_ready",   32'(s_ready),   32'(m_hold ? m_ready : 1'b1));
      check("f1",        32'(f1),        32'(m_f1));
      check("f2",        32'(f2),        32'(m_f2));
      check("f3",        32'(f3),        32'(m_f3));
      check("err_short", 32'(err_short), 32'(m_es));
      check("err_long",  32'(err_long),  32'(m_el));
      check("frame_cnt", 32'(frame_cnt), 32'(16'(m_loads + cnt_base)));
   endtask

   // Drive one cycle of stimulus; ends just after the next rising edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic l);
      s_valid = v; s_data = d; s_last = l;
      @(negedge clk);
      cmp_all();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0);
   endtask

   initial begin
      cnt_base = 0;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle();

      // Basic frame
      step(1, 4'hA, 0); step(1, 4'h5, 0); step(1, 4'hC, 0); step(1, 4'h1, 1);
      check("basic_m_valid", 32'(m_valid), 32'd1);
      check("basic_f1", 32'(f1), 32'hA);
      check("basic_f2", 32'(f2), 32'h05);
      check("basic_f3", 32'(f3), 32'hE);
      check("basic_cnt", 32'(frame_cnt), 32'd1);
      idle();
      check("basic_delivered", 32'(m_valid), 32'd0);

      // Short frame then a good frame with an idle gap
      step(1, 4'h3, 0); step(1, 4'h7, 1);
      check("short_pulse", 32'(err_short), 32'd1);
      check("short_no_valid", 32'(m_valid), 32'd0);
      idle();
      check("short_pulse_end", 32'(err_short), 32'd0);
      step(1, 4'h1, 0); idle(); step(1, 4'h2, 0); step(1, 4'h3, 0); step(1, 4'h0, 1);
      check("after_short_f1", 32'(f1), 32'h1);
      check("after_short_f2", 32'(f2), 32'h12);
      check("after_short_f3", 32'(f3), 32'h1);
      idle();

      // Long frame
      step(1, 4'h1, 0); step(1, 4'h2, 0); step(1, 4'h3, 0); step(1, 4'h4, 0);
      check("long_pulse", 32'(err_long), 32'd1);
      step(1, 4'hF, 0);
      check("long_single_pulse", 32'(err_long), 32'd0);
      step(1, 4'h0, 1);
      check("long_no_valid", 32'(m_valid), 32'd0);
      check("long_cnt", 32'(frame_cnt), 32'd2);
      step(1, 4'hA, 0); step(1, 4'h5, 0); step(1, 4'hC, 0); step(1, 4'h1, 1);
      check("after_long_f1", 32'(f1), 32'hA);
      check("after_long_cnt", 32'(frame_cnt), 32'd3);
      idle();

      // Backpressure then zero-bubble delivery
      m_ready = 1'b0;
      step(1, 4'h1, 0); step(1, 4'h2, 0); step(1, 4'h3, 0); step(1, 4'h4, 1);
      for (int i = 0; i < 5; i++) step(1, 4'h7, 0);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_f2", 32'(f2), 32'h12);
      check("bp_cnt", 32'(frame_cnt), 32'd4);
      m_ready = 1'b1;
      step(1, 4'h6, 0);
      check("bp_delivered", 32'(m_valid), 32'd0);
      step(1, 4'h7, 0); step(1, 4'h8, 0); step(1, 4'h9, 1);
      check("bb_f1", 32'(f1), 32'h6);
      check("bb_f2", 32'(f2), 32'h07);
      check("bb_f3", 32'(f3), 32'hC);
      check("bb_cnt", 32'(frame_cnt), 32'd5);
      idle();

      // Asynchronous reset mid-frame
      step(1, 4'h1, 0); step(1, 4'h2, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_m_valid", 32'(m_valid), 32'd0);
      check("arst_f1", 32'(f1), 32'd0);
      check("arst_cnt", 32'(frame_cnt), 32'd0);
      cmp_all();
      @(posedge clk); #1;
      rst = 1'b0;
      step(1, 4'hA, 0); step(1, 4'h5, 0); step(1, 4'hC, 0); step(1, 4'h1, 1);
      check("post_rst_f1", 32'(f1), 32'hA);
      check("post_rst_cnt", 32'(frame_cnt), 32'd1);
      step(1, 4'h1, 0); step(1, 4'h2, 0); step(1, 4'h3, 0); step(1, 4'h0, 1);
      check("b2b_cnt", 32'(frame_cnt), 32'd2);
      idle();

      // Counter wrap
      force dut.frame_cnt_q = 16'hFFFF;
      cnt_base = 32'hFFFF - m_loads;
      #1 release dut.frame_cnt_q;
      check("preload_cnt", 32'(frame_cnt), 32'hFFFF);
      step(1, 4'hA, 0); step(1, 4'h5, 0); step(1, 4'hC, 0); step(1, 4'h1, 1);
      check("wrap_cnt", 32'(frame_cnt), 32'h0000);
      check("wrap_m_valid", 32'(m_valid), 32'd1);
      idle(); idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
